nibble_serial_sub: RTL and testbench

- Multi-cycle WIDTH-bit subtractor for the ALU: computes D = A - B - bin one 4-bit digit per clock, LSB digit first, with the borrow carried between cycles.
- Area-lean counterpart to the single-cycle 4-bit-block adder chain: same digit slicing, inverse operation, one digit slice reused over time.
- Produces ALU status flags (borrow, zero, negative, signed overflow).
- Sits beside the adder in the ALU; the control unit drives it with a start/done handshake.

---
 rtl/nibble_serial_sub.sv | 121 ++++++++++++
 tb/tb_nibble_serial_sub.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_sub.sv
// Digit-serial subtractor: D = A - B - bin, one DIGIT-bit slice per clock,
// least significant digit first, borrow carried between cycles. Raises ALU
// status flags (borrow, zero, negative, signed overflow) on completion.
module nibble_serial_sub #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             bout,
   output logic             zero,
   output logic             neg,
   output logic             ovf
);

   localparam int unsigned NDig = WIDTH / DIGIT;
   localparam int unsigned CntW = (NDig > 1) ? $clog2(NDig) : 1;
   localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastDig = CntW'(NDig - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, d_q, d_next;
   logic             borrow_q;
   logic [CntW-1:0]  cnt_q;
   logic             bout_q, zero_q, neg_q, ovf_q;
   logic [IdxW-1:0]  base;
   logic [DIGIT-1:0] a_dig, b_dig;
   logic [DIGIT:0]   dig_sum;
   logic             accept, last;

   // Handshake decode: a new op is taken in IDLE or DONE, never in RUN.
   always_comb begin
      accept = (state_q != StRun) && start;
      last   = (state_q == StRun) && (cnt_q == LastDig);
   end

   // Digit slice: subtraction as A + ~B + ~borrow, carry-out inverted is the borrow.
   always_comb begin
      base    = IdxW'(cnt_q) * IdxW'(DIGIT);
      a_dig   = a_q[base +: DIGIT];
      b_dig   = b_q[base +: DIGIT];
      dig_sum = {1'b0, a_dig} + {1'b0, ~b_dig} + {{DIGIT{1'b0}}, ~borrow_q};
      d_next  = d_q;
      d_next[base +: DIGIT] = dig_sum[DIGIT-1:0];
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StRun;
         StRun:   if (cnt_q == LastDig) state_d = StDone;
         StDone:  state_d = start ? StRun : StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy = (state_q == StRun);
      done = (state_q == StDone);
   end

   // Operand capture, digit-by-digit result build and flag registration.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q      <= '0;
         b_q      <= '0;
         d_q      <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         bout_q   <= 1'b0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (accept) begin
         a_q      <= A;
         b_q      <= B;
         borrow_q <= bin;
         cnt_q    <= '0;
      end else if (state_q == StRun) begin
         d_q      <= d_next;
         borrow_q <= ~dig_sum[DIGIT];
         cnt_q    <= cnt_q + CntW'(1);
         if (last) begin
            bout_q <= ~dig_sum[DIGIT];
            zero_q <= (d_next == '0);
            neg_q  <= d_next[WIDTH-1];
            ovf_q  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_next[WIDTH-1] != a_q[WIDTH-1]);
         end
      end
   end

   // Result and flags hold their last completed values outside RUN.
   always_comb begin
      D    = d_q;
      bout = bout_q;
      zero = zero_q;
      neg  = neg_q;
      ovf  = ovf_q;
   end

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Bench for nibble_serial_sub: table of vectors with a scoreboard queue,
// plus hand sequences for back-to-back, start-while-busy and mid-run reset.
module tb_nibble_serial_sub;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        bin = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        busy, done, bout, zero, neg, ovf;
   logic [31:0] D;

   nibble_serial_sub #(.WIDTH(32), .DIGIT(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .D     (D),
      .bout  (bout),
      .zero  (zero),
      .neg   (neg),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        bin;
      logic [31:0] d;
      logic        bout;
      logic        zero;
      logic        neg;
      logic        ovf;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic bi,
                               input logic [31:0] d, input logic bo, input logic z,
                               input logic n, input logic o);
      vec_t v;
      v.a = a; v.b = b; v.bin = bi; v.d = d; v.bout = bo; v.zero = z; v.neg = n; v.ovf = o;
      return v;
   endfunction

   // Reference: plain 33-bit subtraction, bit 32 is the unsigned borrow.
   function automatic vec_t model(input logic [31:0] a, input logic [31:0] b, input logic bi);
      vec_t        v;
      logic [32:0] diff;
      diff   = {1'b0, a} - {1'b0, b} - {32'd0, bi};
      v.a    = a;
      v.b    = b;
      v.bin  = bi;
      v.d    = diff[31:0];
      v.bout = diff[32];
      v.zero = (diff[31:0] == 32'd0);
      v.neg  = diff[31];
      v.ovf  = (a[31] != b[31]) && (diff[31] != a[31]);
      return v;
   endfunction

   // Drive one start pulse; returns 1 time unit after the accepting edge.
   task automatic launch(input vec_t v, input bit push);
      start = 1'b1;
      A     = v.a;
      B     = v.b;
      bin   = v.bin;
      if (push) exp_q.push_back(v);
      @(posedge clk);
      #1;
      start = 1'b0;
      A     = $urandom;
      B     = $urandom;
      bin   = 1'($urandom_range(0, 1));
   endtask

   // Wait for done (bounded), then check latency, busy and the popped expectation.
   task automatic wait_done(input string tag, input int already);
      int   cyc;
      bit   got;
      vec_t e;
      cyc = already;
      got = 1'b0;
      while (cyc < 20 && !got) begin
         @(posedge clk);
         cyc++;
         #1;
         if (done) got = 1'b1;
      end
      if (!got) begin
         n_total++;
         $display("FAIL %s_timeout: no done after %0d cycles, expected done at 8", tag, cyc);
         if (exp_q.size() > 0) e = exp_q.pop_front();
      end else begin
         check({tag, "_latency"}, 32'(cyc), 32'd8);
         check({tag, "_busy"}, {31'd0, busy}, 32'd0);
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL %s_sb: done with empty scoreboard, expected no done", tag);
         end else begin
            e = exp_q.pop_front();
            check({tag, "_D"}, D, e.d);
            check({tag, "_bout"}, {31'd0, bout}, {31'd0, e.bout});
            check({tag, "_zero"}, {31'd0, zero}, {31'd0, e.zero});
            check({tag, "_neg"}, {31'd0, neg}, {31'd0, e.neg});
            check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e.ovf});
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
      check({tag, "_D"}, D, 32'd0);
      check({tag, "_bout"}, {31'd0, bout}, 32'd0);
      check({tag, "_zero"}, {31'd0, zero}, 32'd0);
      check({tag, "_neg"}, {31'd0, neg}, 32'd0);
      check({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
   endtask

   initial begin
      int pulses;

      vecs.push_back(mk(32'd5, 32'd3, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(32'd5, 32'd5, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1));
      vecs.push_back(mk(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1,
                        1'b1));
      vecs.push_back(mk(32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(32'hFFFF_FFFF, 32'd0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(32'h1000_0000, 32'd1, 1'b0, 32'h0FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(32'd0, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0));
      for (int i = 0; i < 4; i++) begin
         vecs.push_back(model($urandom, $urandom, 1'($urandom_range(0, 1))));
      end

      // Asynchronous reset at power-up.
      #1 rst = 1'b0;
      #10;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Table: each op after the first is launched in the previous DONE cycle.
      for (int i = 0; i < vecs.size(); i++) begin
         launch(vecs[i], 1'b1);
         wait_done($sformatf("vec%0d", i), 0);
      end
      @(posedge clk);
      #1;
      check("idle_done", {31'd0, done}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);

      // Equal operands, then a start pulsed in the DONE cycle.
      launch(mk(32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1);
      wait_done("eq", 0);
      launch(mk(32'd9, 32'd4, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
      wait_done("b2b", 0);

      // Start while busy must be ignored.
      launch(mk(32'h0000_1000, 32'd1, 1'b0, 32'h0000_0FFF, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1;
      A     = 32'hFFFF_0000;
      B     = 32'h0000_1234;
      bin   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_start_busy", {31'd0, busy}, 32'd1);
      wait_done("busy_start", 3);
      pulses = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      check("busy_start_pulses", 32'(pulses), 32'd0);

      // Reset asserted mid-cycle during RUN aborts immediately.
      launch(mk(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check_all_zero("midrst");
      pulses = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      check("midrst_pulses", 32'(pulses), 32'd0);
      launch(model(32'hCAFE_F00D, 32'h1234_ABCD, 1'b1), 1'b1);
      wait_done("after_rst", 0);
      check("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
